// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped UART transmitter with a 2**FIFO_AW byte FIFO and programmable divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo #(
  parameter int DEFAULT_DIV = 106,
  parameter int FIFO_AW     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic [31:0] reg_dat_di,
  output logic        reg_dat_wait,
  output logic [31:0] reg_stat_do,
  output logic        ser_tx,
  output logic        irq_tx_empty
);
  localparam int DEPTH = 1 << FIFO_AW;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [31:0]        r_div;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  state_t             r_state;
  logic [31:0]        r_bit_cnt;
  logic [31:0]        r_bit_len;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_data;
  logic               r_tx;
  logic               r_irq;

  logic [31:0]        w_div_eff;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [7:0]         w_head;
  logic [FIFO_AW:0]   w_count_next;
  logic               w_bit_end;
  state_t             w_state_next;
  logic [31:0]        w_bit_cnt_next;
  logic [31:0]        w_bit_len_next;
  logic [2:0]         w_bit_idx_next;
  logic [7:0]         w_data_next;
  logic               w_tx_next;
  logic               w_unused;

  assign w_unused = ^reg_dat_di[31:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= 32'(DEFAULT_DIV);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (reg_div_we[i]) r_div[8*i +: 8] <= reg_div_di[8*i +: 8];
      end
    end
  end

  assign w_div_eff  = (r_div < 32'd2) ? 32'd2 : r_div;
  assign reg_div_do = r_div;

  // Fullness uses the registered count only: a pop on the same edge never rescues a push.
  assign w_full       = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push       = reg_dat_we && !w_full;
  assign reg_dat_wait = reg_dat_we && w_full;
  assign w_head       = r_mem[r_rptr];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= reg_dat_di[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Bit length is latched at each bit start so a divider write only affects the next bit.
  assign w_bit_end = (r_bit_cnt == r_bit_len - 32'd1);

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt + 32'd1;
    w_bit_len_next = r_bit_len;
    w_bit_idx_next = r_bit_idx;
    w_data_next    = r_data;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;
    if (r_state != S_IDLE && w_bit_end) begin
      w_bit_cnt_next = '0;
      w_bit_len_next = w_div_eff;
    end
    case (r_state)
      S_IDLE: begin
        w_bit_cnt_next = '0;
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_data_next    = w_head;
          w_state_next   = S_START;
          w_tx_next      = 1'b0;
          w_bit_len_next = w_div_eff;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next   = S_DATA;
          w_bit_idx_next = 3'd0;
          w_tx_next      = r_data[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = ^r_data;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_data[r_bit_idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_next = S_STOP;
          w_tx_next    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_data_next  = w_head;
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_len <= 32'd2;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_tx      <= 1'b1;
      r_irq     <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_bit_len <= w_bit_len_next;
      r_bit_idx <= w_bit_idx_next;
      r_data    <= w_data_next;
      r_tx      <= w_tx_next;
      r_irq     <= (w_count_next == '0) && (w_state_next == S_IDLE);
    end
  end

  always_comb begin
    reg_stat_do                = '0;
    reg_stat_do[0]             = (r_state != S_IDLE);
    reg_stat_do[1]             = w_full;
    reg_stat_do[2]             = w_empty;
    reg_stat_do[FIFO_AW+8:8]   = r_count;
  end

  assign ser_tx       = r_tx;
  assign irq_tx_empty = r_irq;

endmodule
